saber_matvec_sched: RTL and testbench

Sequencer for `poly_mul256_parallel_in` that computes one Saber matrix-vector product b = A·s (or Aᵀ·s) of dimension L×L. For each row it clears the multiplier accumulator and runs L back-to-back 256-coefficient multiplications that accumulate in place. It then streams the row result out of the accumulator into the result BRAM. It sits between the top-level Saber controller (start/done) and the multiplier, polynomial BRAM index logic and result BRAM.

---
 rtl/saber_sched_pkg.sv | 23 ++
 rtl/matvec_index_gen.sv | 65 ++++++
 rtl/saber_matvec_sched.sv | 103 ++++++++++
 tb/tb_saber_matvec_sched.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/saber_sched_pkg.sv
// Shared state encoding and field widths for the Saber matrix-vector sequencer.
package saber_sched_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLEAR,
      S_KICK,
      S_WAIT,
      S_NEXT,
      S_READ,
      S_DONE
   } state_t;

   localparam int unsigned NW_4X  = 64;
   localparam int unsigned NW_64  = 52;

   localparam int unsigned ROW_W  = 2;
   localparam int unsigned WORD_W = 6;
   localparam int unsigned AIDX_W = 4;
   localparam int unsigned SIDX_W = 2;
   localparam int unsigned ADDR_W = ROW_W + WORD_W;

endpackage

// File: rtl/matvec_index_gen.sv
// Row/column/word counters and the derived BRAM indices for the matvec sequencer.
module matvec_index_gen
   import saber_sched_pkg::*;
#(
   parameter int unsigned L = 3
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              load_i,
   input  logic              transpose_i,
   input  logic              mode_4x_i,
   input  logic              col_adv_i,
   input  logic              row_end_i,
   input  logic              word_adv_i,
   input  logic              row_adv_i,
   output logic              j_last_o,
   output logic              i_last_o,
   output logic              word_last_o,
   output logic [AIDX_W-1:0] a_index_o,
   output logic [SIDX_W-1:0] s_index_o,
   output logic [ADDR_W-1:0] res_addr_o
);

   localparam logic [AIDX_W-1:0] LW = AIDX_W'(L);

   logic [ROW_W-1:0]  i_q;
   logic [ROW_W-1:0]  j_q;
   logic [WORD_W-1:0] word_q;
   logic              tr_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         i_q    <= '0;
         j_q    <= '0;
         word_q <= '0;
         tr_q   <= 1'b0;
      end else begin
         if (load_i) begin
            i_q    <= '0;
            j_q    <= '0;
            word_q <= '0;
            tr_q   <= transpose_i;
         end
         if (col_adv_i)  j_q    <= j_q + 1'b1;
         if (row_end_i) begin
            j_q    <= '0;
            word_q <= '0;
         end
         if (word_adv_i) word_q <= word_q + 1'b1;
         if (row_adv_i)  i_q    <= i_q + 1'b1;
      end
   end

   assign j_last_o    = (j_q == ROW_W'(L - 1));
   assign i_last_o    = (i_q == ROW_W'(L - 1));
   assign word_last_o = mode_4x_i ? (word_q == WORD_W'(NW_4X - 1))
                                  : (word_q == WORD_W'(NW_64 - 1));

   // Indices depend only on counter registers, so they hold steady through KICK/WAIT.
   assign a_index_o  = tr_q ? ({2'b00, j_q} * LW + {2'b00, i_q})
                            : ({2'b00, i_q} * LW + {2'b00, j_q});
   assign s_index_o  = j_q;
   assign res_addr_o = {i_q, word_q};

endmodule

// File: rtl/saber_matvec_sched.sv
// Sequencer driving poly_mul256_parallel_in through one L x L matrix-vector product.
module saber_matvec_sched
   import saber_sched_pkg::*;
#(
   parameter int unsigned L = 3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        transpose,
   input  logic        mode_4x,
   output logic        busy,
   output logic        done,
   output logic        mul_rst,
   output logic        mul_acc_clear,
   output logic        mul_read,
   output logic        mul_read64,
   input  logic        mul_done,
   output logic [3:0]  a_index,
   output logic [1:0]  s_index,
   output logic        res_we,
   output logic [7:0]  res_addr
);

   state_t state_q, state_d;
   logic   mode_q, mode_d;
   logic   busy_q, done_q, mul_rst_q, clear_q, read_q, read64_q, we_q;
   logic   j_last, i_last, word_last;
   logic   accept, col_adv, row_end, word_adv, row_adv;

   assign accept   = (state_q == S_IDLE) && start;
   assign col_adv  = (state_q == S_NEXT) && !j_last;
   assign row_end  = (state_q == S_NEXT) && j_last;
   assign word_adv = (state_q == S_READ);
   assign row_adv  = (state_q == S_READ) && word_last && !i_last;

   matvec_index_gen #(.L(L)) u_idx (
      .clk_i       (clk),
      .rst_i       (rst),
      .load_i      (accept),
      .transpose_i (transpose),
      .mode_4x_i   (mode_q),
      .col_adv_i   (col_adv),
      .row_end_i   (row_end),
      .word_adv_i  (word_adv),
      .row_adv_i   (row_adv),
      .j_last_o    (j_last),
      .i_last_o    (i_last),
      .word_last_o (word_last),
      .a_index_o   (a_index),
      .s_index_o   (s_index),
      .res_addr_o  (res_addr)
   );

   always_comb begin
      state_d = state_q;
      mode_d  = accept ? mode_4x : mode_q;
      unique case (state_q)
         S_IDLE:  if (start) state_d = S_CLEAR;
         S_CLEAR: state_d = S_KICK;
         S_KICK:  state_d = S_WAIT;
         S_WAIT:  if (mul_done) state_d = S_NEXT;
         S_NEXT:  state_d = j_last ? S_READ : S_KICK;
         S_READ:  if (word_last) state_d = i_last ? S_DONE : S_CLEAR;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Outputs are decoded from the next state so they are registered yet aligned with state_q.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         mode_q    <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         mul_rst_q <= 1'b1;
         clear_q   <= 1'b0;
         read_q    <= 1'b0;
         read64_q  <= 1'b0;
         we_q      <= 1'b0;
      end else begin
         state_q   <= state_d;
         mode_q    <= mode_d;
         busy_q    <= (state_d != S_IDLE);
         done_q    <= (state_d == S_DONE);
         mul_rst_q <= (state_d != S_WAIT);
         clear_q   <= (state_d == S_CLEAR);
         read_q    <= (state_d == S_READ) && mode_d;
         read64_q  <= (state_d == S_READ) && !mode_d;
         we_q      <= (state_d == S_READ);
      end
   end

   assign busy          = busy_q;
   assign done          = done_q;
   assign mul_rst       = mul_rst_q;
   assign mul_acc_clear = clear_q;
   assign mul_read      = read_q;
   assign mul_read64    = read64_q;
   assign res_we        = we_q;

endmodule

// File: tb/tb_saber_matvec_sched.sv
// Directed bench for saber_matvec_sched with a fixed-latency multiplier stub.
module tb_saber_matvec_sched;

   localparam int TMUL = 20;

   logic       clk, rst, start, transpose, mode_4x, mul_done;
   logic       busy, done, mul_rst, mul_acc_clear, mul_read, mul_read64, res_we;
   logic [3:0] a_index;
   logic [1:0] s_index;
   logic [7:0] res_addr;

   int n_chk, n_pass;
   bit stub_hold;
   int scnt;
   bit hi_prev;

   saber_matvec_sched #(.L(3)) dut (
      .clk           (clk),
      .rst           (rst),
      .start         (start),
      .transpose     (transpose),
      .mode_4x       (mode_4x),
      .busy          (busy),
      .done          (done),
      .mul_rst       (mul_rst),
      .mul_acc_clear (mul_acc_clear),
      .mul_read      (mul_read),
      .mul_read64    (mul_read64),
      .mul_done      (mul_done),
      .a_index       (a_index),
      .s_index       (s_index),
      .res_we        (res_we),
      .res_addr      (res_addr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Multiplier stub: done rises TMUL cycles into WAIT; hold mode keeps it high one extra cycle.
   always @(posedge clk) begin
      if (mul_rst) begin
         scnt <= 0;
         if (!stub_hold || hi_prev) mul_done <= 1'b0;
         hi_prev <= 1'b1;
      end else begin
         hi_prev <= 1'b0;
         scnt <= scnt + 1;
         if (scnt + 1 >= TMUL - 1) mul_done <= 1'b1;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
   endtask

   task automatic run_prod(input logic tr, input logic m4, input int exp_cyc,
                           input int abort_at, input bit poke);
      int exp_a_n[9] = '{0, 1, 2, 3, 4, 5, 6, 7, 8};
      int exp_a_t[9] = '{0, 3, 6, 1, 4, 7, 2, 5, 8};
      int exp_s[9]   = '{0, 1, 2, 0, 1, 2, 0, 1, 2};
      int cyc, kicks, clears, writes, reads, r64s, dones, done_cyc;
      int addr_err, excl_err, stab_err, busy_err, extra, nw;
      logic       prev_rst;
      logic [3:0] cur_a;
      logic [7:0] ea;
      logic [3:0] ka[16];
      logic [1:0] ks[16];
      nw = m4 ? 64 : 52;
      kicks = 0; clears = 0; writes = 0; reads = 0; r64s = 0; dones = 0; done_cyc = 0;
      addr_err = 0; excl_err = 0; stab_err = 0; busy_err = 0; extra = 0;
      cur_a = '0;
      @(negedge clk);
      start = 1'b1; transpose = tr; mode_4x = m4;
      cyc = 0; prev_rst = 1'b1;
      while (cyc < exp_cyc + 50 && dones == 0) begin
         @(negedge clk);
         cyc++;
         start = 1'b0; transpose = ~tr; mode_4x = ~m4;
         if (abort_at != 0 && cyc == abort_at) begin
            check("abort_in_read", res_we, 1);
            rst = 1'b1;
            #1;
            check("abort_busy", busy, 0);
            check("abort_mul_rst", mul_rst, 1);
            check("abort_res_we", res_we, 0);
            check("abort_read", mul_read, 0);
            check("abort_a_index", a_index, 0);
            check("abort_res_addr", res_addr, 0);
            repeat (3) begin
               @(negedge clk);
               if (res_we || busy || done) extra++;
            end
            check("abort_quiet", extra, 0);
            rst = 1'b0;
            return;
         end
         if (poke && (cyc == 50 || cyc == 300)) start = 1'b1;
         if (!mul_rst && prev_rst) begin
            if (kicks < 16) begin
               ka[kicks] = a_index;
               ks[kicks] = s_index;
            end
            kicks++;
            cur_a = a_index;
         end
         if (!mul_rst && a_index != cur_a) stab_err++;
         prev_rst = mul_rst;
         clears += int'(mul_acc_clear);
         reads  += int'(mul_read);
         r64s   += int'(mul_read64);
         if ((int'(mul_acc_clear) + int'(mul_read) + int'(mul_read64)) > 1 ||
             ((mul_read | mul_read64) != res_we) || (mul_acc_clear && res_we))
            excl_err++;
         if (res_we) begin
            ea = {2'(writes / nw), 6'(writes % nw)};
            if (res_addr != ea) addr_err++;
            writes++;
         end
         if (!busy) busy_err++;
         if (done) begin
            dones++;
            done_cyc = cyc;
         end
      end
      if (poke) start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("busy_after_done", busy, 0);
      check("done_one_cycle", done, 0);
      repeat (5) begin
         @(negedge clk);
         if (busy || done) extra++;
      end
      check("idle_after_done", extra, 0);
      check("done_cycle", done_cyc, exp_cyc);
      check("kicks", kicks, 9);
      check("clears", clears, 3);
      check("writes", writes, 3 * nw);
      check("reads", reads, m4 ? 3 * 64 : 0);
      check("read64s", r64s, m4 ? 0 : 3 * 52);
      check("addr_err", addr_err, 0);
      check("excl_err", excl_err, 0);
      check("stab_err", stab_err, 0);
      check("busy_err", busy_err, 0);
      if (kicks == 9) begin
         for (int k = 0; k < 9; k++) begin
            check($sformatf("a_idx%0d", k), ka[k], tr ? exp_a_t[k] : exp_a_n[k]);
            check($sformatf("s_idx%0d", k), ks[k], exp_s[k]);
         end
      end
   endtask

   initial begin
      n_chk = 0; n_pass = 0;
      rst = 1'b1; start = 1'b0; transpose = 1'b0; mode_4x = 1'b0;
      stub_hold = 1'b0; mul_done = 1'b0; scnt = 0; hi_prev = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_mul_rst", mul_rst, 1);
      check("rst_clear", mul_acc_clear, 0);
      check("rst_we", res_we, 0);
      check("rst_a_index", a_index, 0);
      check("rst_s_index", s_index, 0);
      check("rst_res_addr", res_addr, 0);
      rst = 1'b0;
      @(negedge clk);

      run_prod(1'b0, 1'b1, 394, 0, 1'b1);
      run_prod(1'b1, 1'b1, 394, 0, 1'b0);
      run_prod(1'b0, 1'b0, 358, 0, 1'b0);
      stub_hold = 1'b1;
      run_prod(1'b1, 1'b1, 394, 0, 1'b0);
      stub_hold = 1'b0;
      run_prod(1'b0, 1'b1, 394, 220, 1'b0);
      @(negedge clk);
      run_prod(1'b0, 1'b1, 394, 0, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
